// File: rtl/udma_clk_div_gen.sv
// Integer clock divider / strobe generator with period-aligned reconfiguration and config ack.
// Define UDMA_CLK_DIV_EDGE_EN to add registered rise_o/fall_o edge pulses.
module udma_clk_div_gen #(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RESET_DIV  = 0,
  parameter bit          RESET_MODE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             clk_div_mode_i,
  input  logic             clk_div_valid_i,
  output logic             clk_o,
  output logic             strobe_o,
`ifdef UDMA_CLK_DIV_EDGE_EN
  output logic             rise_o,
  output logic             fall_o,
`endif
  output logic             cfg_ack_o
);

  localparam logic [DIV_W-1:0] ResetDiv = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] One      = DIV_W'(1);

  logic [DIV_W-1:0] target_q, target_d;
  logic [DIV_W-1:0] counter_q, counter_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             mode_q, mode_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             strobe_q, strobe_d;
  logic             ack_q, ack_d;

  logic             halted;
  logic             tc;
  logic             boundary;
  logic             apply;
  logic [DIV_W-1:0] new_div;
  logic             new_mode;

  always_comb begin
    halted   = (target_q == '0);
    tc       = en_i & ~halted & (counter_q == target_q - One);
    // Toggle mode only reconfigures on the falling edge so the high phase never gets cut short.
    boundary = tc & (mode_q | clk_q);
    apply    = (halted | ~en_i | boundary) & (pend_q | clk_div_valid_i);
    new_div  = clk_div_valid_i ? clk_div_i : pend_div_q;
    new_mode = clk_div_valid_i ? clk_div_mode_i : pend_mode_q;
  end

  always_comb begin
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    if (apply) begin
      pend_d = 1'b0;
    end else if (clk_div_valid_i) begin
      pend_d      = 1'b1;
      pend_div_d  = clk_div_i;
      pend_mode_d = clk_div_mode_i;
    end
  end

  always_comb begin
    target_d  = target_q;
    mode_d    = mode_q;
    counter_d = counter_q;
    clk_d     = clk_q;
    strobe_d  = 1'b0;
    ack_d     = 1'b0;
    if (apply) begin
      target_d  = new_div;
      mode_d    = new_mode;
      counter_d = '0;
      clk_d     = 1'b0;
      ack_d     = 1'b1;
    end else if (halted) begin
      counter_d = '0;
      clk_d     = 1'b0;
    end else if (en_i) begin
      counter_d = tc ? '0 : counter_q + One;
      if (mode_q) begin
        clk_d    = 1'b0;
        strobe_d = tc;
      end else if (tc) begin
        clk_d = ~clk_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      target_q    <= ResetDiv;
      mode_q      <= RESET_MODE;
      counter_q   <= '0;
      pend_q      <= 1'b0;
      pend_div_q  <= '0;
      pend_mode_q <= 1'b0;
      clk_q       <= 1'b0;
      strobe_q    <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      target_q    <= target_d;
      mode_q      <= mode_d;
      counter_q   <= counter_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      clk_q       <= clk_d;
      strobe_q    <= strobe_d;
      ack_q       <= ack_d;
    end
  end

  assign clk_o     = clk_q;
  assign strobe_o  = strobe_q;
  assign cfg_ack_o = ack_q;

`ifdef UDMA_CLK_DIV_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= clk_d & ~clk_q;
      fall_q <= clk_q & ~clk_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule
